// File: rtl/mem_scrubber.sv
// Memory scrubber: fills an address window with a seeded incrementing pattern,
// or reads the window back and counts mismatches against that pattern.
module mem_scrubber #(
   parameter int unsigned WIDTH    = 80,
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned OFFSET   = 32,
   parameter int unsigned AW       = 6,
   parameter int unsigned SYNCREAD = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_op,
   input  logic [WIDTH-1:0]             cmd_seed,
   output logic                         done,
   output logic [$clog2(DEPTH+1)-1:0]   err_count,
   output logic [AW-1:0]                first_err_addr,
   output logic                         ren,
   output logic [AW-1:0]                raddr,
   input  logic [WIDTH-1:0]             rdata,
   output logic                         wen,
   output logic [AW-1:0]                waddr,
   output logic [WIDTH-1:0]             wdata
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam bit          SR = (SYNCREAD != 0);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t           state, state_n;
   logic [CW-1:0]    idx, idx_n;
   logic [WIDTH-1:0] seed;
   logic             p_valid;
   logic [AW-1:0]    p_addr;

   logic             accept;
   logic             last;
   logic [AW-1:0]    cur_addr;
   logic             cmp_en;
   logic [AW-1:0]    cmp_addr;
   logic [AW-1:0]    cmp_rel;
   logic [WIDTH-1:0] cmp_exp;
   logic             mismatch;

   assign accept   = cmd_valid && (state == IDLE);
   assign last     = (idx == CW'(DEPTH - 1));
   assign cur_addr = AW'(OFFSET) + AW'(idx);

   // Next state, walk index and memory-port decode
   always_comb begin
      state_n   = state;
      idx_n     = idx;
      cmd_ready = 1'b0;
      done      = 1'b0;
      wen       = 1'b0;
      ren       = 1'b0;
      waddr     = '0;
      wdata     = '0;
      raddr     = '0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               idx_n   = '0;
               state_n = cmd_op ? READ : FILL;
            end
         end
         FILL: begin
            wen   = 1'b1;
            waddr = cur_addr;
            wdata = seed + WIDTH'(idx);
            idx_n = idx + CW'(1);
            if (last) state_n = DONE;
         end
         READ: begin
            ren   = SR;
            raddr = cur_addr;
            idx_n = idx + CW'(1);
            if (last) state_n = SR ? DRAIN : DONE;
         end
         DRAIN: state_n = DONE;
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Compare against the live address (async memory) or the registered one (sync memory)
   assign cmp_en   = SR ? p_valid : (state == READ);
   assign cmp_addr = SR ? p_addr : raddr;
   assign cmp_rel  = cmp_addr - AW'(OFFSET);
   assign cmp_exp  = seed + WIDTH'(cmp_rel);
   assign mismatch = cmp_en && (rdata != cmp_exp);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         idx            <= '0;
         seed           <= '0;
         p_valid        <= 1'b0;
         p_addr         <= '0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         p_valid <= (state == READ);
         p_addr  <= raddr;
         if (accept) seed <= cmd_seed;
         // err_count==0 marks that no mismatch has been seen yet in this CHECK
         if (accept && cmd_op) begin
            err_count      <= '0;
            first_err_addr <= '0;
         end else if (mismatch) begin
            if (err_count != CW'(DEPTH)) err_count <= err_count + CW'(1);
            if (err_count == '0) first_err_addr <= cmp_addr;
         end
      end
   end

endmodule
